// File: rtl/fas_freq_analysis_if.sv
// Bus between the 16-point FFT and the frequency analysis stage.
`timescale 1ns/1ps
interface fas_freq_analysis_if #(
    parameter int unsigned DW = 16
);
    logic            fft_valid;
    logic [2*DW-1:0] fft_d [16];
    logic            done;
    logic [3:0]      freq;
    logic            ovf;

    // FFT side drives frames and observes results
    modport master (
        output fft_valid,
        output fft_d,
        input  done,
        input  freq,
        input  ovf
    );

    // Analysis side consumes frames and produces results
    modport slave (
        input  fft_valid,
        input  fft_d,
        output done,
        output freq,
        output ovf
    );
endinterface

// File: rtl/fas_freq_analysis.sv
// Frequency analysis: scans one 16-bin FFT frame per 16 cycles and reports
// the index of the bin with the largest squared magnitude.
`timescale 1ns/1ps
module fas_freq_analysis #(
    parameter int unsigned DW        = 16,
    parameter int unsigned FIRST_BIN = 0
) (
    input  logic              clk,
    input  logic              rst,
    fas_freq_analysis_if.slave bus
);
    localparam int unsigned W  = 2 * DW;
    localparam logic [3:0]  FB = 4'(FIRST_BIN);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   act_q  [16];
    logic [W-1:0]   act_d  [16];
    logic [W-1:0]   pend_q [16];
    logic [W-1:0]   pend_d [16];
    logic           pend_vld_q, pend_vld_d;
    logic [3:0]     idx_q, idx_d;
    logic [W-1:0]   best_mag_q, best_mag_d;
    logic [3:0]     best_idx_q, best_idx_d;
    logic [3:0]     freq_q, freq_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    logic signed [DW-1:0] re, im;
    logic signed [W-1:0]  re_sq, im_sq;
    logic [W-1:0]         mag;
    logic                 better, last;

    // Squared magnitude of the bin currently addressed by the scan index
    always_comb begin
        re     = act_q[idx_q][W-1:DW];
        im     = act_q[idx_q][DW-1:0];
        re_sq  = re * re;
        im_sq  = im * im;
        mag    = $unsigned(re_sq) + $unsigned(im_sq);
        better = (mag > best_mag_q);
        last   = (idx_q == 4'd15);
    end

    // Next-state logic: frame intake, scan progress and pending-bank handling
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        idx_d      = idx_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        freq_d     = freq_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.fft_valid) begin
                    act_d      = bus.fft_d;
                    idx_d      = FB;
                    best_mag_d = '0;
                    best_idx_d = FB;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    freq_d     = better ? idx_q : best_idx_q;
                    done_d     = 1'b1;
                    idx_d      = FB;
                    best_mag_d = '0;
                    best_idx_d = FB;
                    // Pending frame has priority; a simultaneous new frame
                    // refills the pending bank without counting as overflow.
                    if (pend_vld_q) begin
                        act_d = pend_q;
                        if (bus.fft_valid) begin
                            pend_d = bus.fft_d;
                        end else begin
                            pend_vld_d = 1'b0;
                        end
                    end else if (bus.fft_valid) begin
                        act_d = bus.fft_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (better) begin
                        best_mag_d = mag;
                        best_idx_d = idx_q;
                    end
                    if (bus.fft_valid) begin
                        pend_d     = bus.fft_d;
                        pend_vld_d = 1'b1;
                        if (pend_vld_q) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            idx_q      <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            freq_q     <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            idx_q      <= idx_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            freq_q     <= freq_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Frame storage; contents are qualified by state and pending flag
    always_ff @(posedge clk) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

    assign bus.done = done_q;
    assign bus.freq = freq_q;
    assign bus.ovf  = ovf_q;
endmodule
